// File: rtl/pixel_pkg.sv
// Shared types and constants for the sprite pixel sink.
package pixel_pkg;

    localparam int unsigned SCREEN_W_DFLT = 160;
    localparam int unsigned SCREEN_H_DFLT = 120;

    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 12;
    localparam int unsigned ADDR_W   = 15;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } pix_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FILL
    } fsm_state_t;

    // Row-major frame-buffer address: y * width + x.
    function automatic logic [ADDR_W-1:0] lin_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y,
                                                   input int unsigned    width);
        logic [31:0] a;
        a = 32'(y) * width + 32'(x);
        return a[ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/pixel_plot_sink_if.sv
// Sprite pixel stream: valid/ready handshake carrying (x, y, colour, opaque).
interface pixel_plot_sink_if;
    import pixel_pkg::*;

    logic                pix_valid;
    logic                pix_ready;
    logic [X_W-1:0]      pix_x;
    logic [Y_W-1:0]      pix_y;
    logic [COLOUR_W-1:0] pix_colour;
    logic                pix_opaque;

    modport master (
        output pix_valid, pix_x, pix_y, pix_colour, pix_opaque,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_colour, pix_opaque,
        output pix_ready
    );

endinterface

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of frame-buffer writes; DEPTH must be a power of two.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  pix_entry_t             wr_data,
    output pix_entry_t             rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    pix_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: nothing is read until it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/pixel_plot_sink.sv
// Sprite pixel sink: clips, linearises and buffers pixels, drains them to the
// frame-buffer write port and sequences a whole-screen fill.
// Optional build macro TRANSPARENT_KEY_EN drops non-opaque KEY_COLOUR pixels.
module pixel_plot_sink
    import pixel_pkg::*;
#(
    parameter int unsigned         SCREEN_W   = SCREEN_W_DFLT,
    parameter int unsigned         SCREEN_H   = SCREEN_H_DFLT,
    parameter int unsigned         DEPTH      = 4,
    parameter logic [COLOUR_W-1:0] KEY_COLOUR = 12'h000
) (
    input  logic                clk,
    input  logic                reset,
    pixel_plot_sink_if.slave    pix,
    input  logic                fill_req,
    input  logic [COLOUR_W-1:0] fill_colour,
    output logic                fill_done,
    input  logic                frame_start,
    input  logic                mem_busy,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_wdata,
    output logic [15:0]         pix_count,
    output logic [7:0]          clip_count,
    output logic                idle
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] FILL_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    fsm_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [COLOUR_W-1:0] fill_colour_q, fill_colour_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [COLOUR_W-1:0] mem_wdata_q, mem_wdata_d;
    logic                fill_done_q, fill_done_d;
    logic [15:0]         pix_count_q, pix_count_d;
    logic [7:0]          clip_count_q, clip_count_d;

    logic             accept, on_screen, keyed, fifo_push, fifo_pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] unused_fifo_count;
    pix_entry_t       push_entry, head_entry;

    assign pix.pix_ready = !reset && (state_q == IDLE) && !fifo_full;
    assign accept        = pix.pix_valid && pix.pix_ready;
    assign on_screen     = (32'(pix.pix_x) < SCREEN_W) && (32'(pix.pix_y) < SCREEN_H);

`ifdef TRANSPARENT_KEY_EN
    assign keyed = (pix.pix_colour == KEY_COLOUR) && !pix.pix_opaque;
`else
    logic unused_key;
    assign unused_key = ^{pix.pix_opaque, KEY_COLOUR};
    assign keyed      = 1'b0;
`endif

    assign fifo_push  = accept && on_screen && !keyed;
    assign push_entry = '{addr: lin_addr(pix.pix_x, pix.pix_y, SCREEN_W),
                          colour: pix.pix_colour};

    pixel_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (unused_fifo_count)
    );

    // Next state: FIFO drain or fill sequencing, plus the write-port registers.
    always_comb begin
        state_d       = state_q;
        fill_addr_d   = fill_addr_q;
        fill_colour_d = fill_colour_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        fill_done_d   = 1'b0;
        fifo_pop      = 1'b0;

        // FIFO is always empty in FILL, so draining only matters elsewhere.
        if (state_q != FILL && !fifo_empty && !mem_busy) begin
            fifo_pop    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = head_entry.addr;
            mem_wdata_d = head_entry.colour;
        end

        unique case (state_q)
            IDLE: begin
                if (fill_req) begin
                    state_d       = DRAIN;
                    fill_colour_d = fill_colour;
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_d     = FILL;
                    fill_addr_d = '0;
                end
            end
            FILL: begin
                if (!mem_busy) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = fill_addr_q;
                    mem_wdata_d = fill_colour_q;
                    if (fill_addr_q == FILL_LAST) begin
                        fill_done_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        fill_addr_d = fill_addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Saturating statistics; frame_start wins over hold but a same-edge write counts.
    always_comb begin
        pix_count_d  = pix_count_q;
        clip_count_d = clip_count_q;
        if (mem_we_d) begin
            if (frame_start)              pix_count_d = 16'd1;
            else if (pix_count_q != '1)   pix_count_d = pix_count_q + 1'b1;
        end else if (frame_start) begin
            pix_count_d = '0;
        end
        if (accept && !on_screen && clip_count_q != '1) clip_count_d = clip_count_q + 1'b1;
    end

    // State and output registers; reset aborts any drain or fill in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            fill_addr_q   <= '0;
            fill_colour_q <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            fill_done_q   <= 1'b0;
            pix_count_q   <= '0;
            clip_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            fill_addr_q   <= fill_addr_d;
            fill_colour_q <= fill_colour_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            fill_done_q   <= fill_done_d;
            pix_count_q   <= pix_count_d;
            clip_count_q  <= clip_count_d;
        end
    end

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fill_done  = fill_done_q;
    assign pix_count  = pix_count_q;
    assign clip_count = clip_count_q;
    assign idle       = (state_q == IDLE) && fifo_empty && !mem_we_q;

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Bench for pixel_plot_sink: a queue model of expected frame-buffer writes,
// one per-cycle compare process, and directed scenarios with literal checks.
module tb_pixel_plot_sink;
    import pixel_pkg::*;

    localparam int W    = 160;
    localparam int H    = 120;
    localparam int NPIX = W * H;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fill_req = 1'b0;
    logic [11:0] fill_colour = '0;
    logic        fill_done;
    logic        frame_start = 1'b0;
    logic        mem_busy = 1'b0;
    logic        mem_we;
    logic [14:0] mem_addr;
    logic [11:0] mem_wdata;
    logic [15:0] pix_count;
    logic [7:0]  clip_count;
    logic        idle;

    pixel_plot_sink_if pix_bus ();

    pixel_plot_sink dut (
        .clk         (clk),
        .reset       (reset),
        .pix         (pix_bus),
        .fill_req    (fill_req),
        .fill_colour (fill_colour),
        .fill_done   (fill_done),
        .frame_start (frame_start),
        .mem_busy    (mem_busy),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .pix_count   (pix_count),
        .clip_count  (clip_count),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int colour;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   model_pix = 0;
    int   model_clip = 0;
    int   fill_done_seen = 0;
    int   we_seen = 0;
    int   run_len = 0;
    int   max_run = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Model rule for one accepted pixel: clip, optional colour key, else a write.
    task automatic model_accept(input int x, input int y, input int colour, input bit opaque);
        bit drop_key;
        drop_key = 1'b0;
`ifdef TRANSPARENT_KEY_EN
        drop_key = (colour == 0) && !opaque;
`else
        drop_key = opaque && 1'b0;
`endif
        if (x >= W || y >= H) begin
            if (model_clip < 255) model_clip++;
        end else if (!drop_key) begin
            exp_q.push_back('{y * W + x, colour, 1'b0});
        end
    endtask

    task automatic model_fill(input int colour);
        for (int a = 0; a < NPIX; a++) exp_q.push_back('{a, colour, a == NPIX - 1});
    endtask

    // Per-cycle comparison of the write port and counters against the model.
    always @(negedge clk) begin
        exp_t e;
        bit   exp_fd;
        exp_fd = 1'b0;
        if (!reset) begin
            if (mem_we === 1'b1) begin
                we_seen++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (model_pix < 65535) model_pix++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got write addr=%0d data=%0h, required none",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_addr", 32'(mem_addr), e.addr);
                    chk("write_data", 32'(mem_wdata), e.colour);
                    exp_fd = e.last;
                end
            end else begin
                run_len = 0;
            end
            if (fill_done === 1'b1) fill_done_seen++;
            chk("fill_done", 32'(fill_done), 32'(exp_fd));
            chk("pix_count", 32'(pix_count), model_pix);
            chk("clip_count", 32'(clip_count), model_clip);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int x, input int y, input int colour, input bit opaque,
                        output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        pix_bus.pix_x      = 8'(x);
        pix_bus.pix_y      = 7'(y);
        pix_bus.pix_colour = 12'(colour);
        pix_bus.pix_opaque = opaque;
        pix_bus.pix_valid  = 1'b1;
        while (!ok) begin
            @(negedge clk);
            if (pix_bus.pix_ready === 1'b1) ok = 1'b1;
            else if (++n > 200) break;
        end
        if (!ok) begin
            chk("send_timeout", 0, 1);
            pix_bus.pix_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        pix_bus.pix_valid = 1'b0;
        model_accept(x, y, colour, opaque);
    endtask

    task automatic wait_we(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_we !== 1'b1 && n < 100);
        chk(name, 32'(mem_we), 1);
    endtask

    initial begin
        bit ok;
        int acc, viol, n, fd0, we0;
        pix_bus.pix_valid = 1'b0;
        pix_bus.pix_x = '0;
        pix_bus.pix_y = '0;
        pix_bus.pix_colour = '0;
        pix_bus.pix_opaque = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_ready", 32'(pix_bus.pix_ready), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", 32'(mem_wdata), 0);
        chk("rst_pix_count", 32'(pix_count), 0);
        chk("rst_clip_count", 32'(clip_count), 0);
        chk("rst_fill_done", 32'(fill_done), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_idle", 32'(idle), 1);

        // Single pixel latency: write in the cycle after the second edge.
        tick();
        send(5, 3, 12'hF00, 1'b0, ok);
        @(negedge clk);
        chk("lat_t0_we", 32'(mem_we), 0);
        @(negedge clk);
        chk("lat_t1_we", 32'(mem_we), 1);
        chk("lat_addr", 32'(mem_addr), 485);
        chk("lat_wdata", 32'(mem_wdata), 12'hF00);
        chk("lat_pix_count", 32'(pix_count), 1);
        @(negedge clk);
        chk("lat_we_one_cycle", 32'(mem_we), 0);

        // Off-screen pixel is consumed and counted; corner pixel lands at the last address.
        tick();
        send(180, 100, 12'h0F0, 1'b0, ok);
        chk("clip_accept", 32'(ok), 1);
        repeat (4) tick();
        chk("clip_count_lit", 32'(clip_count), 1);
        send(159, 119, 12'h0FF, 1'b0, ok);
        wait_we("corner_we");
        chk("corner_addr", 32'(mem_addr), 19199);

        // Backpressure: only DEPTH pixels fit while the frame buffer is busy.
        repeat (3) tick();
        mem_busy = 1'b1;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            pix_bus.pix_x = 8'(i);
            pix_bus.pix_y = '0;
            pix_bus.pix_colour = 12'(16 + i);
            pix_bus.pix_opaque = 1'b0;
            pix_bus.pix_valid = 1'b1;
            @(negedge clk);
            if (pix_bus.pix_ready !== 1'b1) break;
            tick();
            model_accept(i, 0, 16 + i, 1'b0);
            acc++;
        end
        chk("busy_accepts", acc, 4);
        chk("busy_ready_low", 32'(pix_bus.pix_ready), 0);
        we_seen = 0;
        max_run = 0;
        mem_busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (pix_bus.pix_ready !== 1'b1 && n < 20);
        tick();
        pix_bus.pix_valid = 1'b0;
        model_accept(4, 0, 20, 1'b0);
        send(5, 0, 21, 1'b0, ok);
        repeat (8) tick();
        chk("burst_writes", we_seen, 6);
        chk("burst_no_gaps", max_run, 6);

        // Fill after two buffered pixels; pixels drain first, then the full screen.
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        model_pix = 0;
        mem_busy = 1'b1;
        send(10, 10, 12'hABC, 1'b0, ok);
        send(11, 10, 12'h123, 1'b0, ok);
        fill_colour = 12'h00F;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        model_fill(12'h00F);
        fd0 = fill_done_seen;
        @(negedge clk);
        chk("drain_ready_low", 32'(pix_bus.pix_ready), 0);
        mem_busy = 1'b0;
        viol = 0;
        n = 0;
        while (fill_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
            if (fill_done !== 1'b1 && pix_bus.pix_ready !== 1'b0) viol++;
        end
        chk("fill_finished", 32'(fill_done), 1);
        chk("fill_ready_low", viol, 0);
        chk("fill_pix_count", 32'(pix_count), 19202);
        repeat (3) tick();
        chk("fill_done_pulses", fill_done_seen - fd0, 1);
        chk("fill_idle_after", 32'(idle), 1);

        // Reset mid-fill aborts at once and leaves the block idle.
        fill_colour = 12'h0F0;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
        model_fill(12'h0F0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_we === 1'b1 && mem_addr == 15'd500) && n < 2000);
        chk("abort_reached_500", 32'(mem_addr), 500);
        fd0 = fill_done_seen;
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_fill_done", 32'(fill_done), 0);
        exp_q.delete();
        model_pix = 0;
        model_clip = 0;
        tick();
        chk("abort_ready_in_reset", 32'(pix_bus.pix_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle", 32'(idle), 1);
        chk("abort_pix_count", 32'(pix_count), 0);
        repeat (300) tick();
        chk("abort_no_fill_done", fill_done_seen - fd0, 0);

        // Colour key: non-opaque key colour dropped only when the key feature is built in.
        tick();
        we0 = we_seen;
        send(20, 20, 12'h000, 1'b0, ok);
        send(21, 20, 12'h000, 1'b1, ok);
        repeat (5) tick();
`ifdef TRANSPARENT_KEY_EN
        chk("key_writes", we_seen - we0, 1);
`else
        chk("key_writes", we_seen - we0, 2);
`endif
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
